// File: rtl/memwb_writeback.sv
// rtl/memwb_writeback.sv - MEM/WB write-back stage: result select, load extract, 32x32 regfile, halt FSM
// Optional retire counter enabled by defining MEMWB_WRITEBACK_RETIRE_CNT_EN; otherwise out_retired is 0.
module memwb_writeback #(
  parameter int unsigned CTL_REGWRITE = 0,
  parameter int unsigned CTL_MEMTOREG = 1,
  parameter int unsigned CTL_JAL      = 2,
  parameter int unsigned CTL_LSIZE    = 3,
  parameter int unsigned CTL_LUNS     = 5
) (
  input  logic        in_CLK,
  input  logic        in_CLRn,
  input  logic        in_EN,
  input  logic        in_lock,
  input  logic [31:0] in_is,
  input  logic [31:0] in_pcout,
  input  logic [31:0] in_R,
  input  logic [31:0] in_Memdata,
  input  logic [4:0]  in_p4,
  input  logic [25:0] in_control,
  input  logic        in_go,
  input  logic [4:0]  in_rA,
  input  logic [4:0]  in_rB,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [31:0] out_wb_data,
  output logic [4:0]  out_wb_reg,
  output logic        out_wb_we,
  output logic        out_halt,
  output logic [31:0] out_retired
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rf_q [32];

  logic        ctl_regwrite;
  logic        ctl_memtoreg;
  logic        ctl_jal;
  logic [1:0]  ctl_lsize;
  logic        ctl_luns;

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        wb_we;

  assign ctl_regwrite = in_control[CTL_REGWRITE];
  assign ctl_memtoreg = in_control[CTL_MEMTOREG];
  assign ctl_jal      = in_control[CTL_JAL];
  assign ctl_lsize    = in_control[CTL_LSIZE +: 2];
  assign ctl_luns     = in_control[CTL_LUNS];

  // Sub-word lane select by address offset; word loads ignore the offset.
  always_comb begin
    half_sel = in_R[1] ? in_Memdata[31:16] : in_Memdata[15:0];
    case (in_R[1:0])
      2'd0:    byte_sel = in_Memdata[7:0];
      2'd1:    byte_sel = in_Memdata[15:8];
      2'd2:    byte_sel = in_Memdata[23:16];
      default: byte_sel = in_Memdata[31:24];
    endcase
  end

  always_comb begin
    case (ctl_lsize)
      2'b01:   load_data = ctl_luns ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   load_data = ctl_luns ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: load_data = in_Memdata;
    endcase
  end

  always_comb begin
    if (ctl_jal) begin
      wb_data = in_pcout;
    end else if (ctl_memtoreg) begin
      wb_data = load_data;
    end else begin
      wb_data = in_R;
    end
  end

  assign wb_we = ctl_regwrite & (in_p4 != 5'd0) & in_EN & (state_q == ST_RUN) & in_CLRn;

  assign out_wb_data = wb_data;
  assign out_wb_reg  = in_p4;
  assign out_wb_we   = wb_we;
  assign out_halt    = (state_q == ST_HALTED);

  // Write-through bypass so ID sees the value being written this cycle.
  always_comb begin
    if (in_rA == 5'd0) begin
      out_A = 32'h0;
    end else if (wb_we && (in_rA == in_p4)) begin
      out_A = wb_data;
    end else begin
      out_A = rf_q[in_rA];
    end
  end

  always_comb begin
    if (in_rB == 5'd0) begin
      out_B = 32'h0;
    end else if (wb_we && (in_rB == in_p4)) begin
      out_B = wb_data;
    end else begin
      out_B = rf_q[in_rB];
    end
  end

  always_ff @(posedge in_CLK or negedge in_CLRn) begin
    if (!in_CLRn) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0;
      end
    end else if (wb_we) begin
      rf_q[in_p4] <= wb_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (in_EN && in_lock) state_d = ST_HALTED;
      ST_HALTED: if (in_EN && in_go)   state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge in_CLK or negedge in_CLRn) begin
    if (!in_CLRn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEMWB_WRITEBACK_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (in_EN && (state_q == ST_RUN) && (in_is != 32'h0)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge in_CLK or negedge in_CLRn) begin
    if (!in_CLRn) begin
      retired_q <= 32'h0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign out_retired = retired_q;

  logic unused_in;
  assign unused_in = ^in_control[25:6];
`else
  assign out_retired = 32'h0;

  logic unused_in;
  assign unused_in = ^{in_control[25:6], in_is};
`endif

endmodule

// File: tb/tb_memwb_writeback.sv
// tb/tb_memwb_writeback.sv - directed plus random check of memwb_writeback against a behavioural model
module tb_memwb_writeback;

  logic        in_CLK = 1'b0;
  logic        in_CLRn, in_EN, in_lock, in_go;
  logic [31:0] in_is, in_pcout, in_R, in_Memdata;
  logic [4:0]  in_p4, in_rA, in_rB;
  logic [25:0] in_control;
  logic [31:0] out_A, out_B, out_wb_data, out_retired;
  logic [4:0]  out_wb_reg;
  logic        out_wb_we, out_halt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_rf [32];
  logic        m_halted;
  logic [31:0] m_cnt;

  memwb_writeback dut (
    .in_CLK(in_CLK), .in_CLRn(in_CLRn), .in_EN(in_EN), .in_lock(in_lock),
    .in_is(in_is), .in_pcout(in_pcout), .in_R(in_R), .in_Memdata(in_Memdata),
    .in_p4(in_p4), .in_control(in_control), .in_go(in_go),
    .in_rA(in_rA), .in_rB(in_rB),
    .out_A(out_A), .out_B(out_B), .out_wb_data(out_wb_data),
    .out_wb_reg(out_wb_reg), .out_wb_we(out_wb_we), .out_halt(out_halt),
    .out_retired(out_retired)
  );

  always #5 in_CLK = ~in_CLK;

  function automatic logic [25:0] mk(input logic rw, mtr, jal, input logic [1:0] lsize, input logic luns);
    logic [25:0] c;
    c = '0;
    c[0] = rw; c[1] = mtr; c[2] = jal; c[4:3] = lsize; c[5] = luns;
    return c;
  endfunction

  function automatic logic [31:0] m_wb_data();
    logic [31:0] v;
    int off;
    if (in_control[2]) return in_pcout;
    if (!in_control[1]) return in_R;
    off = int'(in_R[1:0]);
    case (in_control[4:3])
      2'b10: begin
        v = (in_Memdata >> (8 * off)) & 32'h0000_00FF;
        if (!in_control[5] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (in_Memdata >> (16 * int'(in_R[1]))) & 32'h0000_FFFF;
        if (!in_control[5] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = in_Memdata;
    endcase
    return v;
  endfunction

  function automatic logic m_we();
    return in_control[0] && (in_p4 != 0) && in_EN && !m_halted && in_CLRn;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (r == in_p4 && m_we()) return m_wb_data();
    return m_rf[r];
  endfunction

  function automatic logic [31:0] m_ret();
`ifdef MEMWB_WRITEBACK_RETIRE_CNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    m_halted = 1'b0;
    m_cnt    = 32'h0;
  endtask

  // Called at a falling edge; applies one WB-stage cycle and checks before and after the rising edge.
  task automatic step(input logic [25:0] ctl, input logic [4:0] p4, input logic [31:0] r, mem, is,
                      input logic en, lock, go, input logic [4:0] ra, rb);
    logic        we, inc, nh;
    logic [31:0] d;
    in_control = ctl; in_p4 = p4; in_R = r; in_Memdata = mem; in_is = is;
    in_EN = en; in_lock = lock; in_go = go; in_rA = ra; in_rB = rb;
    in_pcout = $urandom;
    #1;
    chk("wb_data", out_wb_data, m_wb_data());
    chk("wb_we", 32'(out_wb_we), 32'(m_we()));
    chk("wb_reg", 32'(out_wb_reg), 32'(p4));
    chk("read_A", out_A, m_read(ra));
    chk("read_B", out_B, m_read(rb));
    chk("halt", 32'(out_halt), 32'(m_halted));
    chk("retired", out_retired, m_ret());
    we  = m_we();
    d   = m_wb_data();
    inc = en && !m_halted && (is != 0);
    nh  = m_halted ? !(en && go) : (en && lock);
    @(posedge in_CLK);
    if (we) m_rf[p4] = d;
    if (inc) m_cnt = m_cnt + 32'd1;
    m_halted = nh;
    #1;
    chk("post_halt", 32'(out_halt), 32'(m_halted));
    chk("post_retired", out_retired, m_ret());
    chk("post_read_A", out_A, m_read(ra));
    @(negedge in_CLK);
  endtask

  task automatic idle_read(input logic [4:0] ra, rb);
    step(26'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, ra, rb);
  endtask

  initial begin
    logic [25:0] c;
    logic [4:0]  p, ra;
    m_reset();
    in_CLRn = 1'b0; in_EN = 1'b0; in_lock = 1'b0; in_go = 1'b0;
    in_is = '0; in_pcout = '0; in_R = '0; in_Memdata = '0;
    in_p4 = '0; in_rA = 5'd5; in_rB = 5'd9; in_control = mk(1, 0, 0, 0, 0);
    @(negedge in_CLK);
    @(negedge in_CLK);
    chk("rst_halt", 32'(out_halt), 32'h0);
    chk("rst_retired", out_retired, 32'h0);
    chk("rst_A", out_A, 32'h0);
    chk("rst_we", 32'(out_wb_we), 32'h0);
    in_CLRn = 1'b1;

    // basic write with same-cycle bypass
    step(mk(1, 0, 0, 0, 0), 5'd5, 32'h1234, 32'h0, 32'h1, 1, 0, 0, 5'd5, 5'd5);
    chk("bypass_r5", out_A, 32'h1234);
    idle_read(5'd5, 5'd0);
    chk("stored_r5", out_A, 32'h1234);

    // byte / half loads
    step(mk(1, 1, 0, 2'b10, 0), 5'd8, 32'h3, 32'h80FF7F01, 32'h2, 1, 0, 0, 5'd8, 5'd5);
    idle_read(5'd8, 5'd0);
    chk("byte_sext", out_A, 32'hFFFF_FF80);
    step(mk(1, 1, 0, 2'b10, 1), 5'd8, 32'h3, 32'h80FF7F01, 32'h3, 1, 0, 0, 5'd8, 5'd8);
    idle_read(5'd8, 5'd0);
    chk("byte_zext", out_A, 32'h0000_0080);
    step(mk(1, 1, 0, 2'b01, 0), 5'd8, 32'h2, 32'h80FF7F01, 32'h4, 1, 0, 0, 5'd8, 5'd0);
    idle_read(5'd8, 5'd0);
    chk("half_sext", out_A, 32'hFFFF_80FF);

    // r0 is never written and reads zero
    step(mk(1, 0, 0, 0, 0), 5'd0, 32'hDEAD, 32'h0, 32'h5, 1, 0, 0, 5'd0, 5'd0);
    chk("r0_we", 32'(out_wb_we), 32'h0);
    chk("r0_read", out_A, 32'h0);

    // halt, dropped write while halted, resume
    step(mk(1, 0, 0, 0, 0), 5'd3, 32'h55, 32'h0, 32'h6, 1, 1, 0, 5'd3, 5'd0);
    chk("halted", 32'(out_halt), 32'h1);
    step(mk(1, 0, 0, 0, 0), 5'd4, 32'h77, 32'h0, 32'h7, 1, 0, 0, 5'd4, 5'd3);
    chk("r4_dropped", out_A, 32'h0);
    chk("r3_kept", out_B, 32'h55);
    step(26'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1, 0, 1, 5'd4, 5'd3);
    chk("resumed", 32'(out_halt), 32'h0);
    step(mk(1, 0, 0, 0, 0), 5'd4, 32'h99, 32'h0, 32'h8, 1, 0, 0, 5'd4, 5'd0);
    idle_read(5'd4, 5'd0);
    chk("r4_after_go", out_A, 32'h99);

    // stall: no write, no count
    step(mk(1, 0, 0, 0, 0), 5'd6, 32'hABCD, 32'h0, 32'h9, 0, 0, 0, 5'd6, 5'd0);
    idle_read(5'd6, 5'd0);
    chk("stall_r6", out_A, 32'h0);

    // JAL link value
    step(mk(1, 1, 1, 2'b10, 0), 5'd31, 32'h3, 32'h80FF7F01, 32'hA, 1, 0, 0, 5'd31, 5'd0);

`ifdef MEMWB_WRITEBACK_RETIRE_CNT_EN
    dut.retired_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step(mk(0, 0, 0, 0, 0), 5'd1, 32'h0, 32'h0, 32'h1, 1, 0, 0, 5'd1, 5'd2);
    chk("retire_wrap", out_retired, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      c = 26'($urandom);
      p = 5'($urandom);
      ra = ($urandom_range(1, 0) == 1) ? p : 5'($urandom);
      step(c, p, $urandom, $urandom, ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom,
           $urandom_range(7, 0) != 0, $urandom_range(19, 0) == 0, $urandom_range(4, 0) == 0,
           ra, 5'($urandom));
    end

    // async reset while halted
    step(mk(1, 0, 0, 0, 0), 5'd7, 32'h1357, 32'h0, 32'h1, 1, 1, 0, 5'd7, 5'd0);
    chk("pre_rst_halt", 32'(out_halt), 32'h1);
    #2;
    in_CLRn = 1'b0;
    #1;
    chk("async_halt", 32'(out_halt), 32'h0);
    chk("async_retired", out_retired, 32'h0);
    m_reset();
    for (int i = 0; i < 32; i++) begin
      in_rA = 5'(i);
      #1;
      chk("async_rf", out_A, 32'h0);
    end
    @(negedge in_CLK);
    in_CLRn = 1'b1;
    step(mk(1, 0, 0, 0, 0), 5'd9, 32'h2468, 32'h0, 32'h1, 1, 0, 0, 5'd9, 5'd7);
    idle_read(5'd9, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
